// File: rtl/core_ctrl.sv
// ============================================================================
// Module   : core_ctrl
// Purpose  : Convolution loop sequencer; emits source/weight addresses per MAC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_init,
  input  logic        out_busy,
  input  logic [3:0]  id,
  input  logic [9:0]  is,
  input  logic [4:0]  iw,
  input  logic [2:0]  kw,
  input  logic [4:0]  ow,
  output logic        exec,
  output logic [11:0] ia,
  output logic [9:0]  wa,
  output logic        k_init,
  output logic        k_fin,
  output logic        s_fin
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [3:0] r_id;
  logic [9:0] r_is;
  logic [4:0] r_iw;
  logic [2:0] r_kw;
  logic [4:0] r_ow;

  // Loop counters always hold the point currently shown on the outputs.
  logic [4:0] r_y;
  logic [4:0] r_x;
  logic [3:0] r_c;
  logic [2:0] r_fy;
  logic [2:0] r_fx;

  logic       w_fx_end;
  logic       w_fy_end;
  logic       w_c_end;
  logic       w_x_end;
  logic       w_kfin_cur;
  logic       w_final_pos;
  logic       w_advance;
  logic [4:0] w_ny;
  logic [4:0] w_nx;
  logic [3:0] w_nc;
  logic [2:0] w_nfy;
  logic [2:0] w_nfx;
  logic       w_nkfin;
  logic [5:0] w_row;
  logic [5:0] w_col;
  logic [11:0] w_nia;

  assign w_fx_end    = (r_fx == r_kw);
  assign w_fy_end    = (r_fy == r_kw);
  assign w_c_end     = (r_c == r_id);
  assign w_x_end     = (r_x == r_ow);
  assign w_kfin_cur  = w_fx_end && w_fy_end && w_c_end;
  assign w_final_pos = (r_y == r_ow) && w_x_end;

  assign w_nfx = w_fx_end ? 3'd0 : r_fx + 3'd1;
  assign w_nfy = w_fx_end ? (w_fy_end ? 3'd0 : r_fy + 3'd1) : r_fy;
  assign w_nc  = (w_fx_end && w_fy_end) ? (w_c_end ? 4'd0 : r_c + 4'd1) : r_c;
  assign w_nx  = w_kfin_cur ? (w_x_end ? 5'd0 : r_x + 5'd1) : r_x;
  assign w_ny  = (w_kfin_cur && w_x_end) ? r_y + 5'd1 : r_y;

  assign w_nkfin = (w_nc == r_id) && (w_nfy == r_kw) && (w_nfx == r_kw);

  assign w_row = {1'b0, w_ny} + {3'd0, w_nfy};
  assign w_col = {1'b0, w_nx} + {3'd0, w_nfx};

  // Modulo-4096 arithmetic: the low 12 bits of the full-width sum are identical.
  assign w_nia = ({8'd0, w_nc} * {2'd0, r_is})
               + ({6'd0, w_row} * {7'd0, r_iw})
               + {6'd0, w_col};

  assign w_advance = ((r_state == S_RUN) && !(w_kfin_cur && (w_final_pos || out_busy)))
                  || ((r_state == S_WAIT) && !out_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= 4'd0;
      r_is    <= 10'd0;
      r_iw    <= 5'd0;
      r_kw    <= 3'd0;
      r_ow    <= 5'd0;
      r_y     <= 5'd0;
      r_x     <= 5'd0;
      r_c     <= 4'd0;
      r_fy    <= 3'd0;
      r_fx    <= 3'd0;
      exec    <= 1'b0;
      ia      <= 12'd0;
      wa      <= 10'd0;
      k_init  <= 1'b0;
      k_fin   <= 1'b0;
      s_fin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_init) begin
            r_id    <= id;
            r_is    <= is;
            r_iw    <= iw;
            r_kw    <= kw;
            r_ow    <= ow;
            r_y     <= 5'd0;
            r_x     <= 5'd0;
            r_c     <= 4'd0;
            r_fy    <= 3'd0;
            r_fx    <= 3'd0;
            exec    <= 1'b1;
            ia      <= 12'd0;
            wa      <= 10'd0;
            k_init  <= 1'b1;
            k_fin   <= (id == 4'd0) && (kw == 3'd0);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_kfin_cur && (w_final_pos || out_busy)) begin
            exec   <= 1'b0;
            k_init <= 1'b0;
            k_fin  <= 1'b0;
            if (w_final_pos) begin
              s_fin   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!out_busy) begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          s_fin   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Step to the next loop point; a new position restarts the weight count.
      if (w_advance) begin
        r_y    <= w_ny;
        r_x    <= w_nx;
        r_c    <= w_nc;
        r_fy   <= w_nfy;
        r_fx   <= w_nfx;
        exec   <= 1'b1;
        ia     <= w_nia;
        wa     <= w_kfin_cur ? 10'd0 : wa + 10'd1;
        k_init <= w_kfin_cur;
        k_fin  <= w_nkfin;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_ctrl.sv
// ============================================================================
// Module   : tb_core_ctrl
// Purpose  : Directed self-checking bench for core_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_core_ctrl;

  logic        clk;
  logic        rst;
  logic        s_init;
  logic        out_busy;
  logic [3:0]  id;
  logic [9:0]  is;
  logic [4:0]  iw;
  logic [2:0]  kw;
  logic [4:0]  ow;
  logic        exec;
  logic [11:0] ia;
  logic [9:0]  wa;
  logic        k_init;
  logic        k_fin;
  logic        s_fin;

  core_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .s_init   (s_init),
    .out_busy (out_busy),
    .id       (id),
    .is       (is),
    .iw       (iw),
    .kw       (kw),
    .ow       (ow),
    .exec     (exec),
    .ia       (ia),
    .wa       (wa),
    .k_init   (k_init),
    .k_fin    (k_fin),
    .s_fin    (s_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int q_pk[$];
  int exp_q[$];
  int n_sfin;
  int sfin_cyc;
  int first_exec;
  int last_exec;
  int gap;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pk(input int a, input int w, input int ki, input int kf);
    return a + w * 4096 + ki * (1 << 22) + kf * (1 << 23);
  endfunction

  function automatic int outs_now();
    return pk(int'(ia), int'(wa), int'(k_init), int'(k_fin)) + int'(exec) * (1 << 24)
         + int'(s_fin) * (1 << 25);
  endfunction

  task automatic set_cfg(input int a_id, input int a_kw, input int a_ow, input int a_iw, input int a_is);
    id = 4'(a_id);
    kw = 3'(a_kw);
    ow = 5'(a_ow);
    iw = 5'(a_iw);
    is = 10'(a_is);
  endtask

  task automatic pulse_init();
    @(posedge clk);
    #1 s_init = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Records every exec cycle; optionally holds out_busy after the first k_fin,
  // re-pulses s_init mid-run, or pulses s_init during the s_fin cycle.
  task automatic run_sample(input int busy_len, input int repulse_at, input bit done_pulse, input int budget);
    int busy_rem;
    bit trig;
    busy_rem   = 0;
    trig       = 1'b0;
    q_pk.delete();
    n_sfin     = 0;
    sfin_cyc   = -1;
    first_exec = -1;
    last_exec  = -1;
    gap        = 0;
    pulse_init();
    for (int cyc = 0; cyc < budget; cyc++) begin
      s_init = 1'b0;
      if (exec) begin
        q_pk.push_back(pk(int'(ia), int'(wa), int'(k_init), int'(k_fin)));
        if (first_exec < 0) first_exec = cyc;
        if (last_exec >= 0) gap += cyc - last_exec - 1;
        last_exec = cyc;
        if (repulse_at >= 0 && q_pk.size() == repulse_at) s_init = 1'b1;
        if (busy_len > 0 && k_fin && !trig) begin
          trig     = 1'b1;
          busy_rem = busy_len;
        end
      end
      if (s_fin) begin
        n_sfin++;
        if (sfin_cyc < 0) sfin_cyc = cyc;
        if (done_pulse) s_init = 1'b1;
      end
      out_busy = (busy_rem > 0);
      if (busy_rem > 0) busy_rem--;
      if (sfin_cyc >= 0 && cyc > sfin_cyc + 2) break;
      @(posedge clk);
      #1;
    end
    s_init   = 1'b0;
    out_busy = 1'b0;
  endtask

  task automatic check_run(input string nm, input int nexec, input int gap_exp);
    check_val({nm, "_nexec"}, q_pk.size(), nexec);
    check_val({nm, "_nsfin"}, n_sfin, 1);
    check_val({nm, "_first"}, first_exec, 0);
    check_val({nm, "_sfin_lat"}, sfin_cyc - last_exec, 1);
    check_val({nm, "_gap"}, gap, gap_exp);
  endtask

  task automatic check_seq(input string nm);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_val($sformatf("%s_pt%0d", nm, i), (i < q_pk.size()) ? q_pk[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    int cnt;
    int bad_cnt;
    rst      = 1'b1;
    s_init   = 1'b0;
    out_busy = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", outs_now(), 0);
    rst = 1'b0;

    // 2x2 kernel, single channel, one output position
    set_cfg(0, 1, 0, 4, 16);
    run_sample(0, -1, 1'b0, 30);
    check_run("k2", 4, 0);
    exp_q = '{pk(0, 0, 1, 0), pk(1, 1, 0, 0), pk(4, 2, 0, 0), pk(5, 3, 0, 1)};
    check_seq("k2");

    // 1x1 kernel, two channels, 2x2 outputs, no back-pressure
    set_cfg(1, 0, 1, 2, 4);
    run_sample(0, -1, 1'b0, 40);
    check_run("c2", 8, 0);
    exp_q = '{pk(0, 0, 1, 0), pk(4, 1, 0, 1), pk(1, 0, 1, 0), pk(5, 1, 0, 1),
              pk(2, 0, 1, 0), pk(6, 1, 0, 1), pk(3, 0, 1, 0), pk(7, 1, 0, 1)};
    check_seq("c2");

    // same, out_busy held 3 cycles from the first k_fin
    run_sample(3, -1, 1'b0, 40);
    check_run("busy", 8, 3);
    check_seq("busy");

    // s_init re-pulsed mid-run must be ignored
    run_sample(0, 2, 1'b0, 40);
    check_run("repulse", 8, 0);
    check_seq("repulse");

    // degenerate single MAC; s_init in the DONE cycle must not start a run
    set_cfg(0, 0, 0, 3, 5);
    run_sample(0, -1, 1'b1, 20);
    check_run("one", 1, 0);
    exp_q = '{pk(0, 0, 1, 1)};
    check_seq("one");

    // channel stride overflowing 12 bits
    set_cfg(7, 0, 0, 0, 1023);
    run_sample(0, -1, 1'b0, 30);
    check_run("trunc", 8, 0);
    exp_q = '{pk(0, 0, 1, 0), pk(1023, 1, 0, 0), pk(2046, 2, 0, 0), pk(3069, 3, 0, 0),
              pk(4092, 4, 0, 0), pk(1019, 5, 0, 0), pk(2042, 6, 0, 0), pk(3065, 7, 0, 1)};
    check_seq("trunc");

    // 3x3 outputs, 3 channels, 3x3 kernel: 243 MACs, last ia = 2*100+4*10+4
    set_cfg(2, 2, 2, 10, 100);
    run_sample(0, -1, 1'b0, 300);
    check_run("big", 243, 0);
    check_val("big_first", (q_pk.size() > 0) ? q_pk[0] : -1, pk(0, 0, 1, 0));
    check_val("big_last", (q_pk.size() > 0) ? q_pk[q_pk.size() - 1] : -1, pk(244, 26, 0, 1));

    // reset during the third exec aborts without s_fin
    set_cfg(0, 1, 0, 4, 16);
    pulse_init();
    s_init = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (exec) cnt++;
      if (cnt == 3) break;
      @(posedge clk);
      #1;
    end
    check_val("abort_reached", cnt, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_outs", outs_now(), 0);
    bad_cnt = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (exec || s_fin) bad_cnt++;
      @(posedge clk);
      #1;
    end
    check_val("abort_quiet", bad_cnt, 0);
    run_sample(0, -1, 1'b0, 30);
    check_run("rerun", 4, 0);
    exp_q = '{pk(0, 0, 1, 0), pk(1, 1, 0, 0), pk(4, 2, 0, 0), pk(5, 3, 0, 1)};
    check_seq("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
